// File: rtl/snake_body_if.sv
// Game-SM / renderer side signals of the snake body engine.
// master = game SM + renderer, slave = snake_body_engine.
interface snake_body_if;
    logic       q_I;
    logic       q_Run;
    logic       Tick;
    logic [1:0] Dir;
    logic [3:0] Food_X;
    logic [3:0] Food_Y;
    logic [7:0] Rd_Idx;
    logic [3:0] Rd_X;
    logic [3:0] Rd_Y;
    logic       Rd_Valid;
    logic [3:0] Head_X;
    logic [3:0] Head_Y;
    logic [7:0] Length;
    logic       Collision;
    logic       Ate;
    logic       Busy;

    modport master (
        output q_I, q_Run, Tick, Dir, Food_X, Food_Y, Rd_Idx,
        input  Rd_X, Rd_Y, Rd_Valid, Head_X, Head_Y, Length, Collision, Ate, Busy
    );

    modport slave (
        input  q_I, q_Run, Tick, Dir, Food_X, Food_Y, Rd_Idx,
        output Rd_X, Rd_Y, Rd_Valid, Head_X, Head_Y, Length, Collision, Ate, Busy
    );
endinterface

// File: rtl/snake_body_engine.sv
// Snake body datapath: circular segment buffer, head advance, growth and collision detection.
// Optional macro SNAKE_WRAP_WALLS_EN: wall exits wrap to the opposite edge instead of colliding.
module snake_body_engine #(
    parameter int unsigned GRID_W    = 15,
    parameter int unsigned GRID_H    = 15,
    parameter int unsigned MAX_LEN   = 225,
    parameter int unsigned START_LEN = 3,
    parameter int unsigned START_X   = 7,
    parameter int unsigned START_Y   = 7
) (
    input logic        Clk,
    input logic        Reset,
    snake_body_if.slave bus
);
    localparam int unsigned AW = $clog2(MAX_LEN);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_WAIT, S_CALC, S_SCAN, S_COMMIT} state_t;

    state_t          state;
    logic [PW-1:0]   hp;
    logic [PW-1:0]   scan_ptr;
    logic [1:0]      cur_dir;
    logic [1:0]      nxt_dir;
    logic [7:0]      init_cnt;
    logic [7:0]      scan_k;
    logic [3:0]      nx_q, ny_q;
    logic            grow_q;
    logic [3:0]      head_x, head_y;
    logic [7:0]      length;
    logic            collision, ate, busy, rd_valid_q;

    logic [7:0]      mem [MAX_LEN];
    logic [7:0]      scan_data, rd_data;

    logic [1:0]      eff_dir;
    logic [3:0]      nx_c, ny_c;
    logic            wall_c, wall_hit, grow_c, rd_hit;
    logic [PW-1:0]   hp_inc;
    logic [7:0]      scan_lim;
    logic            wr_en;
    logic [AW-1:0]   wr_addr, scan_addr, rd_addr;
    logic [7:0]      wr_data;

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        return (p == '0) ? PW'(MAX_LEN - 1) : p - 1'b1;
    endfunction

    always_comb begin
        eff_dir = (bus.Dir == (cur_dir ^ 2'd2)) ? cur_dir : bus.Dir;
        nx_c    = head_x;
        ny_c    = head_y;
        wall_c  = 1'b0;
        unique case (eff_dir)
            2'd0: if (head_y == '0) begin wall_c = 1'b1; ny_c = 4'(GRID_H - 1); end
                  else ny_c = head_y - 4'd1;
            2'd1: if (head_x == 4'(GRID_W - 1)) begin wall_c = 1'b1; nx_c = '0; end
                  else nx_c = head_x + 4'd1;
            2'd2: if (head_y == 4'(GRID_H - 1)) begin wall_c = 1'b1; ny_c = '0; end
                  else ny_c = head_y + 4'd1;
            2'd3: if (head_x == '0) begin wall_c = 1'b1; nx_c = 4'(GRID_W - 1); end
                  else nx_c = head_x - 4'd1;
        endcase
`ifdef SNAKE_WRAP_WALLS_EN
        wall_hit = 1'b0;
`else
        wall_hit = wall_c;
`endif
        grow_c   = ({nx_c, ny_c} == {bus.Food_X, bus.Food_Y}) && (length < 8'(MAX_LEN));
        hp_inc   = (hp == PW'(MAX_LEN - 1)) ? '0 : hp + 1'b1;
        // Tail vacates this move unless growing, so it is excluded from the scan.
        scan_lim = grow_q ? length : length - 8'd1;
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (state == S_INIT) begin
            wr_en   = 1'b1;
            wr_addr = AW'(init_cnt);
            wr_data = {4'(START_X - START_LEN + 1) + init_cnt[3:0], 4'(START_Y)};
        end else if (state == S_COMMIT) begin
            wr_en   = 1'b1;
            wr_addr = AW'(hp_inc);
            wr_data = {nx_q, ny_q};
        end
        scan_addr = AW'((state == S_CALC) ? hp : scan_ptr);
        rd_hit    = bus.Rd_Idx < length;
        if (!rd_hit)
            rd_addr = '0;
        else if ({1'b0, bus.Rd_Idx} <= hp)
            rd_addr = AW'(hp - {1'b0, bus.Rd_Idx});
        else
            rd_addr = AW'(hp + PW'(MAX_LEN) - {1'b0, bus.Rd_Idx});
    end

    always_ff @(posedge Clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        scan_data <= mem[scan_addr];
        rd_data   <= mem[rd_addr];
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= S_IDLE;
            hp         <= '0;
            scan_ptr   <= '0;
            cur_dir    <= 2'd1;
            nxt_dir    <= 2'd1;
            init_cnt   <= '0;
            scan_k     <= '0;
            nx_q       <= '0;
            ny_q       <= '0;
            grow_q     <= 1'b0;
            head_x     <= '0;
            head_y     <= '0;
            length     <= '0;
            collision  <= 1'b0;
            ate        <= 1'b0;
            busy       <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            ate        <= 1'b0;
            rd_valid_q <= rd_hit;
            if (bus.q_I) begin
                state     <= S_INIT;
                init_cnt  <= '0;
                collision <= 1'b0;
                busy      <= 1'b1;
            end else begin
                unique case (state)
                    S_IDLE: state <= S_IDLE;
                    S_INIT: begin
                        if (init_cnt == 8'(START_LEN - 1)) begin
                            state     <= S_WAIT;
                            busy      <= 1'b0;
                            hp        <= PW'(START_LEN - 1);
                            length    <= 8'(START_LEN);
                            cur_dir   <= 2'd1;
                            collision <= 1'b0;
                            head_x    <= 4'(START_X);
                            head_y    <= 4'(START_Y);
                        end else begin
                            init_cnt <= init_cnt + 8'd1;
                        end
                    end
                    S_WAIT: begin
                        if (bus.Tick && bus.q_Run && !collision) begin
                            state <= S_CALC;
                            busy  <= 1'b1;
                        end
                    end
                    S_CALC: begin
                        if (!bus.q_Run) begin
                            state <= S_WAIT;
                            busy  <= 1'b0;
                        end else if (wall_hit) begin
                            collision <= 1'b1;
                            state     <= S_WAIT;
                            busy      <= 1'b0;
                        end else begin
                            // Direction is held pending so an aborted move leaves cur_dir untouched.
                            nxt_dir  <= eff_dir;
                            nx_q     <= nx_c;
                            ny_q     <= ny_c;
                            grow_q   <= grow_c;
                            scan_k   <= '0;
                            scan_ptr <= ptr_dec(hp);
                            state    <= S_SCAN;
                        end
                    end
                    S_SCAN: begin
                        if (!bus.q_Run) begin
                            state <= S_WAIT;
                            busy  <= 1'b0;
                        end else if (scan_k < scan_lim && scan_data == {nx_q, ny_q}) begin
                            collision <= 1'b1;
                            state     <= S_WAIT;
                            busy      <= 1'b0;
                        end else if (scan_k + 8'd1 >= scan_lim) begin
                            state <= S_COMMIT;
                        end else begin
                            scan_k   <= scan_k + 8'd1;
                            scan_ptr <= ptr_dec(scan_ptr);
                        end
                    end
                    S_COMMIT: begin
                        hp      <= hp_inc;
                        length  <= length + 8'(grow_q);
                        ate     <= grow_q;
                        head_x  <= nx_q;
                        head_y  <= ny_q;
                        cur_dir <= nxt_dir;
                        state   <= S_WAIT;
                        busy    <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.Rd_X      = rd_valid_q ? rd_data[7:4] : '0;
    assign bus.Rd_Y      = rd_valid_q ? rd_data[3:0] : '0;
    assign bus.Rd_Valid  = rd_valid_q;
    assign bus.Head_X    = head_x;
    assign bus.Head_Y    = head_y;
    assign bus.Length    = length;
    assign bus.Collision = collision;
    assign bus.Ate       = ate;
    assign bus.Busy      = busy;
endmodule

// File: tb/tb_snake_body_engine.sv
// Randomized self-checking bench for snake_body_engine against a queue-based snake model.
module tb_snake_body_engine;
    localparam int GW   = 15;
    localparam int GH   = 15;
    localparam int MAXL = 225;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    snake_body_if bus();

    snake_body_engine #(
        .GRID_W(GW), .GRID_H(GH), .MAX_LEN(MAXL),
        .START_LEN(3), .START_X(7), .START_Y(7)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: queue of body cells, index 0 = head.
    int qx[$];
    int qy[$];
    int m_dir;
    int m_col;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic model_init();
        qx = '{7, 6, 5};
        qy = '{7, 7, 7};
        m_dir = 1;
        m_col = 0;
    endtask

    // Returns 1 when the requested move leaves the grid (never in wrap mode).
    function automatic int predict(input int d, output int nd, output int nx, output int ny);
        nd = ((d + 2) % 4 == m_dir) ? m_dir : d;
        nx = qx[0] + ((nd == 1) ? 1 : (nd == 3) ? -1 : 0);
        ny = qy[0] + ((nd == 2) ? 1 : (nd == 0) ? -1 : 0);
`ifdef SNAKE_WRAP_WALLS_EN
        nx = (nx + GW) % GW;
        ny = (ny + GH) % GH;
        return 0;
`else
        return (nx < 0 || nx >= GW || ny < 0 || ny >= GH) ? 1 : 0;
`endif
    endfunction

    task automatic model_move(input int d, input int fx, input int fy, output int ate);
        int nd, nx, ny, off, grow, lim;
        ate = 0;
        if (m_col != 0) return;
        off = predict(d, nd, nx, ny);
        if (off != 0) begin
            m_col = 1;
            return;
        end
        grow = (nx == fx && ny == fy && qx.size() < MAXL) ? 1 : 0;
        lim  = (grow != 0) ? qx.size() : qx.size() - 1;
        for (int k = 0; k < lim; k++) begin
            if (qx[k] == nx && qy[k] == ny) begin
                m_col = 1;
                return;
            end
        end
        m_dir = nd;
        qx.push_front(nx);
        qy.push_front(ny);
        if (grow == 0) begin
            void'(qx.pop_back());
            void'(qy.pop_back());
        end
        ate = grow;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_head_x"}, bus.Head_X, qx[0]);
        check({tag, "_head_y"}, bus.Head_Y, qy[0]);
        check({tag, "_length"}, bus.Length, qx.size());
        check({tag, "_collision"}, bus.Collision, m_col);
    endtask

    task automatic read_all(input string tag);
        int n;
        n = qx.size();
        for (int i = 0; i <= n; i++) begin
            bus.Rd_Idx = 8'(i);
            step();
            if (i < n) begin
                check({tag, "_rd_x"}, bus.Rd_X, qx[i]);
                check({tag, "_rd_y"}, bus.Rd_Y, qy[i]);
                check({tag, "_rd_valid"}, bus.Rd_Valid, 1);
            end else begin
                check({tag, "_rd_end_valid"}, bus.Rd_Valid, 0);
                check({tag, "_rd_end_xy"}, {bus.Rd_X, bus.Rd_Y}, 0);
            end
        end
        bus.Rd_Idx = 8'd255;
        step();
        check({tag, "_rd_far_valid"}, bus.Rd_Valid, 0);
        bus.Rd_Idx = 8'd0;
    endtask

    task automatic do_init();
        bus.q_I = 1'b1;
        step();
        check("init_busy", bus.Busy, 1);
        bus.q_I = 1'b0;
        step();
        step();
        step();
        model_init();
        check("init_busy_done", bus.Busy, 0);
        check_state("init");
    endtask

    // drop: 0 = normal, 1 = q_Run low during CALC, 2 = q_Run low during SCAN
    task automatic do_move(input int d, input int fx, input int fy, input int drop, input string tag);
        int ate_seen, n, m_ate, nd, nx, ny, off;
        ate_seen = 0;
        n = 0;
        off = predict(d, nd, nx, ny);
        bus.Dir    = 2'(d);
        bus.Food_X = 4'(fx);
        bus.Food_Y = 4'(fy);
        bus.Tick   = 1'b1;
        step();
        bus.Tick = 1'b0;
        if (drop == 1) bus.q_Run = 1'b0;
        ate_seen += int'(bus.Ate);
        if (drop == 2) begin
            step();
            ate_seen += int'(bus.Ate);
            bus.q_Run = 1'b0;
        end
        while (bus.Busy && n < 300) begin
            step();
            ate_seen += int'(bus.Ate);
            n++;
        end
        check({tag, "_busy_bound"}, bus.Busy, 0);
        bus.q_Run = 1'b1;
        m_ate = 0;
        if (drop == 0 || (drop == 2 && off != 0))
            model_move(d, fx, fy, m_ate);
        check({tag, "_ate"}, ate_seen, m_ate);
        check_state(tag);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd, nx, ny, off, fx, fy, drop;
        Reset      = 1'b1;
        bus.q_I    = 1'b0;
        bus.q_Run  = 1'b0;
        bus.Tick   = 1'b0;
        bus.Dir    = 2'd1;
        bus.Food_X = '0;
        bus.Food_Y = '0;
        bus.Rd_Idx = '0;
        step();
        step();
        check("rst_busy", bus.Busy, 0);
        check("rst_length", bus.Length, 0);
        check("rst_head", {bus.Head_X, bus.Head_Y}, 0);
        check("rst_collision", bus.Collision, 0);
        check("rst_ate", bus.Ate, 0);
        check("rst_rd", {bus.Rd_Valid, bus.Rd_X, bus.Rd_Y}, 0);
        Reset = 1'b0;
        step();

        do_init();
        read_all("init");

        // Tick without q_Run is dropped.
        bus.Tick = 1'b1;
        step();
        bus.Tick = 1'b0;
        step();
        step();
        check("norun_busy", bus.Busy, 0);
        check_state("norun");
        bus.q_Run = 1'b1;

        for (int i = 0; i < 3; i++) do_move(1, 0, 0, 0, "right");
        check("right3_x", bus.Head_X, 10);
        do_move(1, 11, 7, 0, "eat");
        check("eat_len", bus.Length, 4);
        read_all("eat");
        do_move(3, 0, 0, 0, "reverse");
        do_move(1, 0, 0, 0, "to_edge");
        do_move(1, 0, 0, 0, "to_edge");
        do_move(1, 0, 0, 0, "wall");
`ifndef SNAKE_WRAP_WALLS_EN
        check("wall_col", bus.Collision, 1);
        check("wall_head_x", bus.Head_X, 14);
`endif
        do_move(2, 0, 0, 0, "sticky");

        do_init();
        do_move(1, 8, 7, 0, "grow_a");
        do_move(1, 9, 7, 0, "grow_b");
        do_move(2, 0, 0, 0, "coil_down");
        do_move(3, 0, 0, 0, "coil_left");
        do_move(0, 0, 0, 0, "coil_up");
        check("self_col", bus.Collision, 1);

        do_init();
        do_move(2, 0, 0, 1, "abort_calc");
        do_move(0, 0, 0, 2, "abort_scan");
        do_move(0, 0, 0, 0, "after_abort");
        do_move(1, 0, 0, 0, "after_abort2");

        // 2x2 tail chase, long enough to wrap the head pointer.
        do_init();
        do_move(1, 8, 7, 0, "chase_grow");
        for (int i = 0; i < 240; i++) begin
            case (i % 4)
                0: do_move(2, 0, 0, 0, "chase");
                1: do_move(3, 0, 0, 0, "chase");
                2: do_move(0, 0, 0, 0, "chase");
                default: do_move(1, 0, 0, 0, "chase");
            endcase
            if (i % 40 == 39) read_all("chase");
        end
        check("chase_col", bus.Collision, 0);

        do_init();
        for (int i = 0; i < 300; i++) begin
            if (m_col != 0) do_init();
            nd  = int'($urandom_range(0, 3));
            off = predict(nd, fx, nx, ny);
            if (off == 0 && $urandom_range(0, 2) == 0) begin
                fx = nx;
                fy = ny;
            end else begin
                fx = int'($urandom_range(0, GW - 1));
                fy = int'($urandom_range(0, GH - 1));
            end
            drop = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
            do_move(nd, fx, fy, drop, "rand");
            if (i % 25 == 24) read_all("rand");
        end

        // Asynchronous reset while scanning.
        if (m_col != 0) do_init();
        bus.Dir    = 2'(m_dir);
        bus.Food_X = '0;
        bus.Food_Y = '0;
        bus.Tick   = 1'b1;
        step();
        bus.Tick = 1'b0;
        step();
        check("scan_busy", bus.Busy, 1);
        #1 Reset = 1'b1;
        #1;
        check("midrst_busy", bus.Busy, 0);
        check("midrst_length", bus.Length, 0);
        check("midrst_head", {bus.Head_X, bus.Head_Y}, 0);
        check("midrst_flags", {bus.Collision, bus.Ate, bus.Rd_Valid}, 0);
        check("midrst_rd", {bus.Rd_X, bus.Rd_Y}, 0);
        step();
        Reset = 1'b0;
        step();
        do_init();
        read_all("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
